// File: rtl/fir_test_pkg.sv
// Shared definitions for the fir_test stimulus path: mode codes, LFSR polynomial,
// generator FSM states and the LFSR step function.
package fir_test_pkg;

    localparam logic [1:0] MODE_IMPULSE = 2'd0;
    localparam logic [1:0] MODE_STEP    = 2'd1;
    localparam logic [1:0] MODE_SQUARE  = 2'd2;
    localparam logic [1:0] MODE_LFSR    = 2'd3;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } stim_state_t;

    // Galois right-shift step; the mask is applied when the bit shifted out is 1
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/fir_stim_lfsr.sv
// 32-bit Galois LFSR used as the noise source of fir_stim_gen.
module fir_stim_lfsr
    import fir_test_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE12345
) (
    input  logic        fclk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] state
);

    always_ff @(posedge fclk or posedge reset) begin
        if (reset)
            state <= SEED;
        else if (load)
            state <= seed;
        else if (advance)
            state <= lfsr_next(state);
    end

endmodule

// File: rtl/fir_stim_gen.sv
// Programmable zero-order-hold sample source (impulse/step/square/noise) feeding
// the sfix32 input of the FIR datapath.
module fir_stim_gen
    import fir_test_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE12345
) (
    input  logic             fclk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [31:0]      amplitude,
    input  logic [CNT_W-1:0] length,
    input  logic [CNT_W-1:0] rate_div,
    input  logic [CNT_W-1:0] half_period,
    output logic [31:0]      sample_out,
    output logic             sample_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    stim_state_t      state;
    logic [1:0]       mode_r;
    logic [31:0]      amp_r;
    logic [CNT_W-1:0] rate_r;
    logic [CNT_W-1:0] half_r;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] rem_cnt;
    logic [CNT_W-1:0] ph_cnt;
    logic             neg;

    logic [31:0]      lfsr_state;
    logic             lfsr_load;
    logic             emit_next;
    logic [CNT_W-1:0] half_eff;
    logic [CNT_W-1:0] next_ph;
    logic             next_neg;
    logic [31:0]      next_sample;
    logic [31:0]      first_sample;

    fir_stim_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .fclk    (fclk),
        .reset   (reset),
        .load    (lfsr_load),
        .seed    (LFSR_SEED),
        .advance (emit_next),
        .state   (lfsr_state)
    );

    // Next-sample values are computed ahead so each new sample lands registered
    // in the same cycle sample_valid rises; the LFSR register holds the last one.
    always_comb begin
        lfsr_load = (state == ST_IDLE) && start;
        emit_next = (state == ST_RUN) && !abort && (hold_cnt == '0) && (rem_cnt != '0);
        half_eff  = (half_r == '0) ? ONE : half_r;
        if (ph_cnt == half_eff) begin
            next_neg = ~neg;
            next_ph  = ONE;
        end else begin
            next_neg = neg;
            next_ph  = ph_cnt + ONE;
        end
        case (mode_r)
            MODE_IMPULSE: next_sample = '0;
            MODE_STEP:    next_sample = amp_r;
            MODE_SQUARE:  next_sample = next_neg ? (~amp_r + 32'd1) : amp_r;
            default:      next_sample = lfsr_next(lfsr_state);
        endcase
        first_sample = (mode == MODE_LFSR) ? LFSR_SEED : amplitude;
    end

    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            mode_r       <= MODE_IMPULSE;
            amp_r        <= '0;
            rate_r       <= '0;
            half_r       <= '0;
            hold_cnt     <= '0;
            rem_cnt      <= '0;
            ph_cnt       <= '0;
            neg          <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sample_valid <= 1'b0;
                    done         <= 1'b0;
                    if (start) begin
                        mode_r <= mode;
                        amp_r  <= amplitude;
                        rate_r <= rate_div;
                        half_r <= half_period;
                        if (length != '0) begin
                            state        <= ST_RUN;
                            hold_cnt     <= rate_div;
                            rem_cnt      <= length - ONE;
                            ph_cnt       <= ONE;
                            neg          <= 1'b0;
                            sample_out   <= first_sample;
                            sample_valid <= 1'b1;
                            busy         <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    sample_valid <= 1'b0;
                    if (abort || (hold_cnt == '0 && rem_cnt == '0)) begin
                        state      <= ST_DONE;
                        sample_out <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - ONE;
                    end else begin
                        hold_cnt     <= rate_r;
                        rem_cnt      <= rem_cnt - ONE;
                        ph_cnt       <= next_ph;
                        neg          <= next_neg;
                        sample_out   <= next_sample;
                        sample_valid <= 1'b1;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    sample_out   <= '0;
                    sample_valid <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stim_gen.sv
// Directed scoreboard bench for fir_stim_gen: expected samples are queued at
// start and popped on each sample_valid; timing of valid/busy/done is checked per cycle.
module tb_fir_stim_gen;
    import fir_test_pkg::*;

    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] SEED  = 32'hACE12345;

    logic             fclk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [31:0]      amplitude = '0;
    logic [CNT_W-1:0] length = '0;
    logic [CNT_W-1:0] rate_div = '0;
    logic [CNT_W-1:0] half_period = '0;
    logic [31:0]      sample_out;
    logic             sample_valid;
    logic             busy;
    logic             done;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_q[$];

    fir_stim_gen #(
        .CNT_W     (CNT_W),
        .LFSR_SEED (SEED)
    ) dut (
        .fclk         (fclk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .mode         (mode),
        .amplitude    (amplitude),
        .length       (length),
        .rate_div     (rate_div),
        .half_period  (half_period),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 fclk = ~fclk;

    function automatic logic [31:0] model_lfsr(input logic [31:0] x);
        logic [31:0] y;
        y = {1'b0, x[31:1]};
        if (x[0]) y = y ^ 32'h80200003;
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // abort_c/poke_c: cycle after acceptance (1 = first sample cycle) in which
    // abort or a stray start is asserted; 0 disables it.
    task automatic run_case(input string tag, input logic [1:0] m, input logic [31:0] amp,
                            input int unsigned len, input int unsigned rate,
                            input int unsigned half, input int unsigned abort_c,
                            input int unsigned poke_c);
        int unsigned per;
        int unsigned n_emit;
        int unsigned end_c;
        int unsigned h;
        logic [31:0] lf;
        logic [31:0] held;
        logic [31:0] v;
        logic        act;
        per    = rate + 1;
        h      = (half == 0) ? 1 : half;
        n_emit = (abort_c != 0) ? (abort_c - 1) / per + 1 : len;
        end_c  = (abort_c != 0) ? abort_c + 1 : len * per + 1;
        lf     = SEED;
        held   = '0;
        for (int unsigned n = 0; n < n_emit; n++) begin
            case (m)
                MODE_IMPULSE: v = (n == 0) ? amp : 32'd0;
                MODE_STEP:    v = amp;
                MODE_SQUARE:  v = (((n / h) % 2) == 1) ? (32'd0 - amp) : amp;
                default: begin
                    v  = lf;
                    lf = model_lfsr(lf);
                end
            endcase
            exp_q.push_back(v);
        end
        @(negedge fclk);
        mode        = m;
        amplitude   = amp;
        length      = CNT_W'(len);
        rate_div    = CNT_W'(rate);
        half_period = CNT_W'(half);
        start       = 1'b1;
        @(posedge fclk);
        #1;
        start       = 1'b0;
        mode        = ~m;
        amplitude   = $urandom;
        length      = CNT_W'($urandom_range(1, 5));
        rate_div    = CNT_W'($urandom_range(0, 3));
        half_period = CNT_W'($urandom_range(0, 3));
        for (int unsigned c = 1; c <= end_c + 1; c++) begin
            @(negedge fclk);
            start = 1'b0;
            abort = 1'b0;
            act   = (c < end_c);
            chk({tag, " busy"}, {31'd0, busy}, {31'd0, act});
            chk({tag, " valid"}, {31'd0, sample_valid}, {31'd0, act && ((c - 1) % per == 0)});
            chk({tag, " done"}, {31'd0, done}, {31'd0, c == end_c});
            if (!act) begin
                chk({tag, " idle_out"}, sample_out, 32'd0);
            end else if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    chk({tag, " extra_sample"}, sample_out, 32'hXXXXXXXX);
                end else begin
                    held = exp_q.pop_front();
                    chk({tag, " sample"}, sample_out, held);
                end
            end else begin
                chk({tag, " hold"}, sample_out, held);
            end
            if (c == abort_c) abort = 1'b1;
            if (c == poke_c) start = 1'b1;
        end
        chk({tag, " missing_samples"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #1;
        chk("reset out", sample_out, 32'd0);
        chk("reset valid", {31'd0, sample_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        #20;
        @(negedge fclk);
        reset = 1'b0;

        run_case("impulse", MODE_IMPULSE, 32'h7FFFFFFF, 9, 0, 0, 0, 0);
        run_case("step_div", MODE_STEP, 32'h00001000, 3, 2, 0, 0, 0);
        run_case("square_hp2", MODE_SQUARE, 32'd5, 6, 0, 2, 0, 0);
        run_case("square_hp0", MODE_SQUARE, 32'd5, 6, 0, 0, 0, 0);
        run_case("lfsr_a", MODE_LFSR, 32'd0, 3, 0, 0, 0, 0);
        run_case("lfsr_b", MODE_LFSR, 32'd0, 3, 0, 0, 0, 0);
        run_case("lfsr_div", MODE_LFSR, 32'd0, 4, 1, 0, 0, 0);
        run_case("len0", MODE_STEP, 32'h12345678, 0, 0, 0, 0, 0);
        run_case("start_in_run", MODE_STEP, 32'h00000777, 5, 1, 0, 0, 3);
        run_case("square_min", MODE_SQUARE, 32'h80000000, 4, 0, 1, 0, 0);
        run_case("abort", MODE_STEP, 32'h0000ABCD, 10, 0, 0, 4, 0);
        run_case("abort_div", MODE_SQUARE, 32'h00000003, 10, 2, 1, 8, 0);

        // asynchronous reset in the middle of a run
        @(negedge fclk);
        mode      = MODE_STEP;
        amplitude = 32'h00C0FFEE;
        length    = CNT_W'(10);
        rate_div  = '0;
        start     = 1'b1;
        @(posedge fclk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge fclk);
        chk("pre_reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset out", sample_out, 32'd0);
        chk("async_reset valid", {31'd0, sample_valid}, 32'd0);
        chk("async_reset busy", {31'd0, busy}, 32'd0);
        chk("async_reset done", {31'd0, done}, 32'd0);
        @(negedge fclk);
        reset = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge fclk);
            chk("post_reset done", {31'd0, done}, 32'd0);
            chk("post_reset busy", {31'd0, busy}, 32'd0);
        end

        run_case("lfsr_after_reset", MODE_LFSR, 32'd0, 3, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
